// File: rtl/conv2d_stream_engine_pkg.sv
// Shared types and sizing helpers for the streaming 2-D convolution engine.
// Holds the LOAD/EXE state enum plus clog2, ofm_dim and acc_w sizing functions.
package conv_pkg;

   typedef enum logic {
      LOAD = 1'b0,
      EXE  = 1'b1
   } state_t;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      result = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((32'd1 << i) < value) result = i + 1;
      end
      return result;
   endfunction

   function automatic int unsigned ofm_dim(input int unsigned ifm, input int unsigned k,
                                           input int unsigned stride);
      return (ifm - k) / stride + 1;
   endfunction

   function automatic int unsigned acc_w(input int unsigned data_w, input int unsigned k);
      return 2 * data_w + clog2(k * k);
   endfunction

endpackage

// File: rtl/conv2d_stream_engine_if.sv
// Load/stream handshake bundle of the convolution engine: IFM and weight inputs,
// OFM output and busy flag.
interface conv2d_stream_engine_if #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ACC_W  = 36
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_ifm;
   logic              weight_valid;
   logic              weight_ready;
   logic [DATA_W-1:0] in_weight;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  out_ofm;
   logic              busy;

   modport master (
      output in_valid, in_ifm, weight_valid, in_weight, out_ready,
      input  in_ready, weight_ready, out_valid, out_ofm, busy
   );

   modport slave (
      input  in_valid, in_ifm, weight_valid, in_weight, out_ready,
      output in_ready, weight_ready, out_valid, out_ofm, busy
   );
endinterface

// File: rtl/conv2d_stream_engine_window_mac.sv
// Combinational K_DIM x K_DIM signed multiply-accumulate over one window.
// Operands are sign-extended to ACC_W before multiplying, so the sum never truncates.
module conv_window_mac #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned K_DIM  = 3,
   parameter int unsigned ACC_W  = 36
) (
   input  logic [K_DIM*K_DIM*DATA_W-1:0] window,
   input  logic [K_DIM*K_DIM*DATA_W-1:0] kernel,
   output logic signed [ACC_W-1:0]       sum_c
);
   localparam int unsigned K_N = K_DIM * K_DIM;

   always_comb begin
      sum_c = '0;
      for (int i = 0; i < K_N; i++) begin
         sum_c = sum_c + ACC_W'(signed'(window[i*DATA_W +: DATA_W]))
                       * ACC_W'(signed'(kernel[i*DATA_W +: DATA_W]));
      end
   end
endmodule

// File: rtl/conv2d_stream_engine.sv
// Streaming 2-D convolution engine: loads an IFM frame and kernel, then emits OFM in raster order.
// Optional CONV_RELU_EN clamps negative output sums to zero.
module conv2d_stream_engine
   import conv_pkg::*;
#(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned IFM_DIM = 7,
   parameter int unsigned K_DIM   = 3,
   parameter int unsigned STRIDE  = 1
) (
   input logic                  clk,
   input logic                  rst_n,
   conv2d_stream_engine_if.slave bus
);
   localparam int unsigned OFM_DIM   = ofm_dim(IFM_DIM, K_DIM, STRIDE);
   localparam int unsigned ACC_W     = acc_w(DATA_W, K_DIM);
   localparam int unsigned IFM_N     = IFM_DIM * IFM_DIM;
   localparam int unsigned K_N       = K_DIM * K_DIM;
   localparam int unsigned IFM_CNT_W = clog2(IFM_N + 1);
   localparam int unsigned W_CNT_W   = clog2(K_N + 1);
   localparam int unsigned IFM_IDX_W = (IFM_N > 1) ? clog2(IFM_N) : 1;
   localparam int unsigned W_IDX_W   = (K_N > 1) ? clog2(K_N) : 1;
   localparam int unsigned POS_W     = (IFM_DIM > 1) ? clog2(IFM_DIM) : 1;
   localparam int unsigned LAST_POS  = (OFM_DIM - 1) * STRIDE;

   state_t                   state_q, state_d;
   logic [IFM_CNT_W-1:0]     ifm_cnt_q, ifm_cnt_d;
   logic [W_CNT_W-1:0]       w_cnt_q, w_cnt_d;
   logic [POS_W-1:0]         row_q, row_d, col_q, col_d;
   logic                     issued_q, issued_d;
   logic                     in_ready_q, in_ready_d;
   logic                     weight_ready_q, weight_ready_d;
   logic                     out_valid_q, out_valid_d;
   logic                     busy_q, busy_d;
   logic signed [ACC_W-1:0]  out_ofm_q, out_ofm_d;
   logic signed [ACC_W-1:0]  sum_c, relu_c;
   logic [DATA_W-1:0]        ifm_buf [IFM_N];
   logic [DATA_W-1:0]        w_buf   [K_N];
   logic [K_N*DATA_W-1:0]    window_c, kernel_c;
   logic                     ifm_acc_c, w_acc_c;

   assign ifm_acc_c = (state_q == LOAD) && bus.in_valid && in_ready_q;
   assign w_acc_c   = (state_q == LOAD) && bus.weight_valid && weight_ready_q;

   // Gather the current window and kernel into flat vectors for the MAC
   always_comb begin
      window_c = '0;
      kernel_c = '0;
      for (int i = 0; i < K_DIM; i++) begin
         for (int j = 0; j < K_DIM; j++) begin
            window_c[(i*K_DIM+j)*DATA_W +: DATA_W] =
               ifm_buf[IFM_IDX_W'((int'(row_q) + i) * IFM_DIM + int'(col_q) + j)];
            kernel_c[(i*K_DIM+j)*DATA_W +: DATA_W] = w_buf[W_IDX_W'(i * K_DIM + j)];
         end
      end
   end

   conv_window_mac #(.DATA_W(DATA_W), .K_DIM(K_DIM), .ACC_W(ACC_W)) u_mac (
      .window (window_c),
      .kernel (kernel_c),
      .sum_c  (sum_c)
   );

`ifdef CONV_RELU_EN
   assign relu_c = sum_c[ACC_W-1] ? '0 : sum_c;
`else
   assign relu_c = sum_c;
`endif

   // Next-state, counter, window-walk and output-register logic
   always_comb begin
      state_d     = state_q;
      ifm_cnt_d   = ifm_cnt_q;
      w_cnt_d     = w_cnt_q;
      row_d       = row_q;
      col_d       = col_q;
      issued_d    = issued_q;
      out_valid_d = out_valid_q;
      out_ofm_d   = out_ofm_q;
      case (state_q)
         LOAD: begin
            if (ifm_acc_c) ifm_cnt_d = ifm_cnt_q + IFM_CNT_W'(1);
            if (w_acc_c)   w_cnt_d   = w_cnt_q + W_CNT_W'(1);
            if (ifm_cnt_d == IFM_CNT_W'(IFM_N) && w_cnt_d == W_CNT_W'(K_N)) begin
               state_d   = EXE;
               ifm_cnt_d = '0;
               w_cnt_d   = '0;
               row_d     = '0;
               col_d     = '0;
               issued_d  = 1'b0;
            end
         end
         EXE: begin
            if (!out_valid_q || bus.out_ready) begin
               if (issued_q) begin
                  // Final pixel has just been taken downstream
                  out_valid_d = 1'b0;
                  out_ofm_d   = '0;
                  state_d     = LOAD;
               end else begin
                  out_valid_d = 1'b1;
                  out_ofm_d   = relu_c;
                  if (col_q == POS_W'(LAST_POS)) begin
                     col_d = '0;
                     if (row_q == POS_W'(LAST_POS)) begin
                        row_d    = '0;
                        issued_d = 1'b1;
                     end else begin
                        row_d = row_q + POS_W'(STRIDE);
                     end
                  end else begin
                     col_d = col_q + POS_W'(STRIDE);
                  end
               end
            end
         end
         default: state_d = LOAD;
      endcase
      in_ready_d     = (state_d == LOAD) && (ifm_cnt_d < IFM_CNT_W'(IFM_N));
      weight_ready_d = (state_d == LOAD) && (w_cnt_d < W_CNT_W'(K_N));
      busy_d         = (state_d == EXE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= LOAD;
         ifm_cnt_q      <= '0;
         w_cnt_q        <= '0;
         row_q          <= '0;
         col_q          <= '0;
         issued_q       <= 1'b0;
         in_ready_q     <= 1'b1;
         weight_ready_q <= 1'b1;
         out_valid_q    <= 1'b0;
         busy_q         <= 1'b0;
         out_ofm_q      <= '0;
      end else begin
         state_q        <= state_d;
         ifm_cnt_q      <= ifm_cnt_d;
         w_cnt_q        <= w_cnt_d;
         row_q          <= row_d;
         col_q          <= col_d;
         issued_q       <= issued_d;
         in_ready_q     <= in_ready_d;
         weight_ready_q <= weight_ready_d;
         out_valid_q    <= out_valid_d;
         busy_q         <= busy_d;
         out_ofm_q      <= out_ofm_d;
      end
   end

   // Sample buffers, written at the running counter index
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < IFM_N; i++) ifm_buf[IFM_IDX_W'(i)] <= '0;
         for (int i = 0; i < K_N; i++)   w_buf[W_IDX_W'(i)]     <= '0;
      end else begin
         if (ifm_acc_c) ifm_buf[IFM_IDX_W'(ifm_cnt_q)] <= bus.in_ifm;
         if (w_acc_c)   w_buf[W_IDX_W'(w_cnt_q)]       <= bus.in_weight;
      end
   end

   assign bus.in_ready     = in_ready_q;
   assign bus.weight_ready = weight_ready_q;
   assign bus.out_valid    = out_valid_q;
   assign bus.out_ofm      = out_ofm_q;
   assign bus.busy         = busy_q;

endmodule

// File: tb/tb_conv2d_stream_engine.sv
// Directed bench for conv2d_stream_engine: stride-1 and stride-2 instances with
// hand-computed OFM sequences, backpressure, latency and mid-frame reset.
module tb_conv2d_stream_engine;
   import conv_pkg::*;

   localparam int unsigned DATA_W  = 16;
   localparam int unsigned IFM_DIM = 7;
   localparam int unsigned K_DIM   = 3;
   localparam int unsigned ACC_W   = acc_w(DATA_W, K_DIM);
   localparam int unsigned IFM_N   = IFM_DIM * IFM_DIM;
   localparam int unsigned K_N     = K_DIM * K_DIM;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   logic [DATA_W-1:0]       ifm_v [IFM_N];
   logic [DATA_W-1:0]       w_v   [K_N];
   logic signed [ACC_W-1:0] exp_q [$];

   always #5 clk = ~clk;

   conv2d_stream_engine_if #(.DATA_W(DATA_W), .ACC_W(ACC_W)) bus1 ();
   conv2d_stream_engine_if #(.DATA_W(DATA_W), .ACC_W(ACC_W)) bus2 ();

   conv2d_stream_engine #(.DATA_W(DATA_W), .IFM_DIM(IFM_DIM), .K_DIM(K_DIM), .STRIDE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1.slave));
   conv2d_stream_engine #(.DATA_W(DATA_W), .IFM_DIM(IFM_DIM), .K_DIM(K_DIM), .STRIDE(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .bus(bus2.slave));

   task automatic drive(input int sel, input logic iv, input logic [DATA_W-1:0] d,
                        input logic wv, input logic [DATA_W-1:0] w);
      if (sel == 1) begin
         bus1.in_valid = iv; bus1.in_ifm = d; bus1.weight_valid = wv; bus1.in_weight = w;
      end else begin
         bus2.in_valid = iv; bus2.in_ifm = d; bus2.weight_valid = wv; bus2.in_weight = w;
      end
   endtask

   task automatic set_ready(input int sel, input logic r);
      if (sel == 1) bus1.out_ready = r;
      else          bus2.out_ready = r;
   endtask

   task automatic peek(input int sel, output logic ov, output logic [ACC_W-1:0] ofm,
                       output logic ir, output logic wr, output logic bz);
      if (sel == 1) begin
         ov = bus1.out_valid; ofm = bus1.out_ofm; ir = bus1.in_ready; wr = bus1.weight_ready; bz = bus1.busy;
      end else begin
         ov = bus2.out_valid; ofm = bus2.out_ofm; ir = bus2.in_ready; wr = bus2.weight_ready; bz = bus2.busy;
      end
   endtask

   task automatic check_idle(input int sel, input string name);
      logic ov, ir, wr, bz;
      logic [ACC_W-1:0] ofm;
      peek(sel, ov, ofm, ir, wr, bz);
      checks++;
      if ({ov, ir, wr, bz} !== 4'b0110 || ofm !== '0) begin
         errors++;
         $display("FAIL %s dut%0d: valid=%0b ofm=%0d in_ready=%0b weight_ready=%0b busy=%0b, need 0 0 1 1 0",
                  name, sel, ov, $signed(ofm), ir, wr, bz);
      end
   endtask

   // Feed ifm_v / w_v; optional gaps stagger the two streams
   task automatic load_frame(input int sel, input bit gaps);
      int ki = 0, kw = 0, cyc = 0;
      logic iv, wv, ov, ir, wr, bz;
      logic [ACC_W-1:0] ofm;
      while ((ki < IFM_N || kw < K_N) && cyc < 300) begin
         iv = (ki < IFM_N) && !(gaps && (cyc % 3 == 1));
         wv = (kw < K_N) && !(gaps && (cyc % 2 == 0));
         drive(sel, iv, ifm_v[(ki < IFM_N) ? ki : 0], wv, w_v[(kw < K_N) ? kw : 0]);
         peek(sel, ov, ofm, ir, wr, bz);
         @(posedge clk); #1;
         if (iv && ir) ki++;
         if (wv && wr) kw++;
         cyc++;
      end
      drive(sel, 1'b0, '0, 1'b0, '0);
      checks++;
      if (ki != IFM_N || kw != K_N) begin
         errors++;
         $display("FAIL load_timeout dut%0d: ifm=%0d weights=%0d accepted, need %0d %0d", sel, ki, kw, IFM_N, K_N);
      end
   endtask

   // Drain exp_q; mode 0: out_ready held high, mode 1: out_ready pattern 1,0,0,1
   task automatic collect(input int sel, input string name, input int mode, output int first_cyc);
      int idx = 0, cyc = 0;
      bit held = 0, started = 0;
      logic ov, ir, wr, bz, r;
      logic [ACC_W-1:0] ofm, held_val;
      first_cyc = -1;
      while (idx < exp_q.size() && cyc < 400) begin
         r = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
         set_ready(sel, r);
         peek(sel, ov, ofm, ir, wr, bz);
         if (held) begin
            checks++;
            if (ov !== 1'b1 || ofm !== held_val) begin
               errors++;
               $display("FAIL %s stall_hold: valid=%0b ofm=%0d, need 1 %0d", name, ov, $signed(ofm), $signed(held_val));
            end
         end
         if (ov) begin
            if (!started) first_cyc = cyc;
            started = 1;
            if (r) begin
               checks++;
               if (ofm !== exp_q[idx]) begin
                  errors++;
                  $display("FAIL %s pixel %0d: got %0d, need %0d", name, idx, $signed(ofm), exp_q[idx]);
               end
               idx++;
               held = 0;
            end else begin
               held = 1;
               held_val = ofm;
            end
         end else begin
            checks++;
            if (ofm !== '0 || (mode == 0 && started)) begin
               errors++;
               $display("FAIL %s idle_out: valid=0 ofm=%0d started=%0b, need ofm 0 and no gap", name, $signed(ofm), started);
            end
            held = 0;
         end
         @(posedge clk); #1;
         cyc++;
      end
      set_ready(sel, 1'b1);
      checks++;
      if (idx != exp_q.size()) begin
         errors++;
         $display("FAIL %s timeout: %0d pixels, need %0d", name, idx, exp_q.size());
      end
      check_idle(sel, {name, "_ready_after_last"});
   endtask

   task automatic test_reset();
      check_idle(1, "reset_values");
      check_idle(2, "reset_values");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_idle(1, "after_reset_release");
   endtask

   task automatic test_ones();
      int first;
      logic ov, ir, wr, bz;
      logic [ACC_W-1:0] ofm;
      for (int k = 0; k < IFM_N; k++) ifm_v[k] = 16'd1;
      for (int k = 0; k < K_N; k++)   w_v[k]   = 16'd1;
      load_frame(1, 1'b0);
      peek(1, ov, ofm, ir, wr, bz);
      checks++;
      if ({ov, ir, wr, bz} !== 4'b0001) begin
         errors++;
         $display("FAIL ones_exe_entry: valid=%0b in_ready=%0b weight_ready=%0b busy=%0b, need 0 0 0 1", ov, ir, wr, bz);
      end
      exp_q.delete();
      for (int k = 0; k < 25; k++) exp_q.push_back(9);
      collect(1, "ones", 0, first);
      checks++;
      if (first != 1) begin
         errors++;
         $display("FAIL ones_latency: first valid %0d cycles after exe entry, need 1", first);
      end
   endtask

   task automatic load_ramp_centre(input bit gaps);
      for (int k = 0; k < IFM_N; k++) ifm_v[k] = DATA_W'(k);
      for (int k = 0; k < K_N; k++)   w_v[k]   = (k == 4) ? 16'd1 : 16'd0;
      load_frame(1, gaps);
      exp_q.delete();
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 5; c++) exp_q.push_back(8 + 7 * r + c);
   endtask

   task automatic test_ramp_centre();
      int first;
      load_ramp_centre(1'b1);
      collect(1, "ramp_centre", 0, first);
   endtask

   task automatic test_negative();
      int first;
      for (int k = 0; k < IFM_N; k++) ifm_v[k] = 16'd5;
      for (int k = 0; k < K_N; k++)   w_v[k]   = 16'hFFFF;
      load_frame(1, 1'b0);
      exp_q.delete();
`ifdef CONV_RELU_EN
      for (int k = 0; k < 25; k++) exp_q.push_back(0);
`else
      for (int k = 0; k < 25; k++) exp_q.push_back(-45);
`endif
      collect(1, "negative", 0, first);
   endtask

   task automatic test_backpressure();
      int first;
      load_ramp_centre(1'b0);
      collect(1, "backpressure", 1, first);
   endtask

   task automatic test_stride2();
      int first;
      for (int k = 0; k < IFM_N; k++) ifm_v[k] = DATA_W'(k);
      for (int k = 0; k < K_N; k++)   w_v[k]   = (k == 0) ? 16'd1 : 16'd0;
      load_frame(2, 1'b0);
      exp_q.delete();
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++) exp_q.push_back(14 * r + 2 * c);
      collect(2, "stride2", 0, first);
   endtask

   task automatic test_reset_mid();
      int acc = 0, cyc = 0, first;
      logic ov, ir, wr, bz;
      logic [ACC_W-1:0] ofm;
      for (int k = 0; k < IFM_N; k++) ifm_v[k] = 16'd1;
      for (int k = 0; k < K_N; k++)   w_v[k]   = 16'd1;
      load_frame(1, 1'b0);
      while (acc < 9 && cyc < 100) begin
         peek(1, ov, ofm, ir, wr, bz);
         if (ov) acc++;
         @(posedge clk); #1;
         cyc++;
      end
      peek(1, ov, ofm, ir, wr, bz);
      checks++;
      if (ov !== 1'b1 || ofm !== ACC_W'(9)) begin
         errors++;
         $display("FAIL reset_mid_tenth: valid=%0b ofm=%0d, need 1 9", ov, $signed(ofm));
      end
      rst_n = 1'b0;
      #1;
      check_idle(1, "reset_mid");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      load_ramp_centre(1'b0);
      collect(1, "after_reset", 0, first);
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1, 1'b0, '0, 1'b0, '0);
      drive(2, 1'b0, '0, 1'b0, '0);
      set_ready(1, 1'b1);
      set_ready(2, 1'b1);
      @(posedge clk); #1;
      test_reset();
      test_ones();
      test_ramp_centre();
      test_negative();
      test_backpressure();
      test_stride2();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/conv2d_stream_engine.md
# conv2d_stream_engine

Parametrised 2-D convolution engine; successor to the fixed 7×7 IFM / 3×3 kernel unpipelined convolver in the DIC homework series. Loads one IFM frame and one kernel through valid/ready inputs, then streams every output-feature-map pixel in raster order through a valid/ready output. Adds generic sizes, stride, signed arithmetic, input gaps and output backpressure.

## Interface
- DATA_W, 16, IFM and weight sample width, signed two's complement
- IFM_DIM, 7, IFM side length (square frame)
- K_DIM, 3, kernel side length; K_DIM ≤ IFM_DIM
- STRIDE, 1, window step (1 or 2); (IFM_DIM−K_DIM) divisible by STRIDE
- Derived: OFM_DIM = (IFM_DIM−K_DIM)/STRIDE+1; ACC_W = 2·DATA_W + clog2(K_DIM²)
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  IFM sample valid
- in_ready  out  1  IFM sample accepted when in_valid && in_ready
- in_ifm  in  DATA_W  IFM sample, raster order
- weight_valid  in  1  weight sample valid
- weight_ready  out  1  weight accepted when weight_valid && weight_ready
- in_weight  in  DATA_W  weight, raster order
- out_valid  out  1  registered; Out pixel valid
- out_ready  in  1  downstream accepts when out_valid && out_ready
- out_ofm  out  ACC_W  registered signed OFM pixel
- busy  out  1  high in EXE

## Operation
- States: LOAD, EXE. Reset → LOAD.
- LOAD: in_ready = (ifm_cnt < IFM_DIM²); weight_ready = (w_cnt < K_DIM²). Each accepted sample is written at its counter index, counter increments. Gaps (valid low) pause counting; no timeout.
- IFM and weights load independently, in any interleaving, including same cycle.
- LOAD→EXE on the cycle after both counters are full. Both counters clear on entry to EXE.
- EXE: in_ready = weight_ready = 0; input valids ignored. Window origin (row, col) starts at (0,0); output = Σ ifm[row+i][col+j]·w[i][j], full-precision signed, no truncation.
- Window advances only when output register is free (!out_valid || out_ready). col += STRIDE; at last col, col=0, row += STRIDE.
- After last pixel is accepted downstream → LOAD. Buffers retain old data but are fully overwritten by next load.
- out_ofm holds its value while out_valid && !out_ready; out_ofm = 0 whenever out_valid = 0.

## Timing
- Reset values: out_valid 0, out_ofm 0, in_ready 1, weight_ready 1, busy 0; buffers, counters 0.
- First out_valid: 2 cycles after the cycle completing the last load (1 cycle state change, 1 cycle registered MAC).
- With out_ready held high: OFM_DIM² consecutive out_valid cycles, one pixel per cycle.
- Last pixel accepted at cycle T → in_ready/weight_ready high at T+1; new load may start T+1.
- Reset mid-LOAD or mid-EXE: immediate return to reset values; partial frame discarded.

## Configuration
- CONV_RELU_EN defined: out_ofm = max(sum, 0) (negative sums output 0). Undefined: raw signed sum. Latency identical either way.

## Structure
- Package conv_pkg: state enum (LOAD, EXE), functions ofm_dim() and acc_w(), clog2.
- Sub-module conv_window_mac: combinational K_DIM² multiply plus adder tree, inputs flattened window and kernel vectors, output ACC_W sum; parent owns buffers, counters, FSM, output register.

## Test plan
- Defaults, IFM all 1, weights all 1, out_ready=1 → 25 consecutive outputs of 9, first 2 cycles after last load.
- Defaults, IFM ramp 0..48, weight centre 1 others 0 → 8,9,10,11,12,15,...,40 (row stride 7).
- IFM all 5, weights all −1 → 25× −45; with CONV_RELU_EN → 25× 0.
- out_ready toggling 1-0-0-1 during EXE → out_ofm stable while stalled; no pixel lost or repeated.
- STRIDE=2, IFM ramp, weight[0]=1 others 0 → 9 outputs 0,2,4,14,16,18,28,30,32.
- rst_n pulsed at 10th output → all outputs 0; subsequent full load yields correct fresh 25-pixel frame.
